// File: rtl/mmio_input_capture_pkg.sv
// Package: mmio_input_capture_pkg
// Shared definitions for the MMIO input-capture block and its decoder in
// Data_Mamory:
//   - rd_sel codes for the IO read mux
//   - bit positions inside the STATUS word
//   - IO base address used by the data-memory decoder to select this block
//   - debouncer state encoding
package mmio_input_capture_pkg;

  typedef enum logic [1:0] {
    IO_SEL_STATUS = 2'd0,
    IO_SEL_DATA   = 2'd1,
    IO_SEL_COUNT  = 2'd2,
    IO_SEL_LIVE   = 2'd3
  } io_sel_e;

  localparam int STATUS_VALID_BIT   = 0;
  localparam int STATUS_OVERRUN_BIT = 1;

  localparam logic [31:0] IO_INPUT_BASE_ADDR = 32'h0000_FF10;

  typedef enum logic [1:0] {
    DB_IDLE    = 2'd0,
    DB_WAIT_HI = 2'd1,
    DB_HIGH    = 2'd2,
    DB_WAIT_LO = 2'd3
  } db_state_e;

endpackage

// File: rtl/mmio_input_capture_input_debouncer.sv
// Module: input_debouncer
// Two-flop synchroniser plus a four-state debounce FSM for one button.
// The level is accepted only after it has been stable for DEBOUNCE_CYCLES
// consecutive cycles of the counting state; an accepted rising level emits
// exactly one one-cycle press pulse.
// Ports:
//   clk      in  board clock
//   rst      in  asynchronous active-high reset
//   btn_raw  in  raw (asynchronous, bouncing) button pin
//   press    out one-cycle pulse per accepted press
module input_debouncer
  import mmio_input_capture_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20'd100000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          btn_s;
  db_state_e     state, state_nxt;
  logic [CW-1:0] cnt;
  logic          cnt_clr, cnt_inc;

  assign btn_s = sync_q[1];

  // NOTE: sequential state is updated with <= so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], btn_raw};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DB_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so
  // no path through the case statement can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state)
      DB_IDLE: begin
        if (btn_s) begin
          state_nxt = DB_WAIT_HI;
          cnt_clr   = 1'b1;
        end
      end
      DB_WAIT_HI: begin
        if (!btn_s)               state_nxt = DB_IDLE;
        else if (cnt == CNT_LAST) state_nxt = DB_HIGH;
        else                      cnt_inc   = 1'b1;
      end
      DB_HIGH: begin
        if (!btn_s) begin
          state_nxt = DB_WAIT_LO;
          cnt_clr   = 1'b1;
        end
      end
      DB_WAIT_LO: begin
        if (btn_s)                state_nxt = DB_HIGH;
        else if (cnt == CNT_LAST) state_nxt = DB_IDLE;
        else                      cnt_inc   = 1'b1;
      end
      default: state_nxt = DB_IDLE;
    endcase
  end

  // Pulse only on the single WAIT_HI -> HIGH transition; HIGH itself never
  // pulses, so holding the button cannot re-trigger.
  always_comb begin
    press = (state == DB_WAIT_HI) && btn_s && (cnt == CNT_LAST);
  end

endmodule

// File: rtl/mmio_input_capture.sv
// Module: mmio_input_capture
// Input-side MMIO peripheral: debounces the board button, snapshots the
// switches on each accepted press and exposes STATUS/DATA/COUNT/LIVE words
// to the CPU with a read-to-clear handshake.
// Ports:
//   clk       in  board clock
//   rst       in  asynchronous active-high reset
//   sw_raw    in  raw switch pins (asynchronous)
//   btn_raw   in  raw button pin (asynchronous, bouncing)
//   rd_en     in  one-cycle read strobe
//   rd_sel    in  0=STATUS 1=DATA 2=COUNT 3=LIVE
//   sign_ext  in  DATA read sign-extended (1) or zero-extended (0)
//   rd_data   out registered read word
//   valid     out captured data waiting to be read
//   overrun   out a capture happened while valid was already set
module mmio_input_capture
  import mmio_input_capture_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20'd100000,
  parameter int          SW_WIDTH        = 16,
  parameter int          CNT_WIDTH       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SW_WIDTH-1:0] sw_raw,
  input  logic                btn_raw,
  input  logic                rd_en,
  input  logic [1:0]          rd_sel,
  input  logic                sign_ext,
  output logic [31:0]         rd_data,
  output logic                valid,
  output logic                overrun
);

  logic [SW_WIDTH-1:0]  sw_meta, sw_s;
  logic [SW_WIDTH-1:0]  data_q;
  logic [CNT_WIDTH-1:0] press_cnt;
  logic                 press;
  logic                 data_rd, status_rd;
  logic [31:0]          rd_word;

  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_raw),
    .press  (press)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta <= '0;
      sw_s    <= '0;
    end else begin
      sw_meta <= sw_raw;
      sw_s    <= sw_meta;
    end
  end

  assign data_rd   = rd_en && (io_sel_e'(rd_sel) == IO_SEL_DATA);
  assign status_rd = rd_en && (io_sel_e'(rd_sel) == IO_SEL_STATUS);

  always_comb begin
    rd_word = '0;
    unique case (io_sel_e'(rd_sel))
      IO_SEL_STATUS: begin
        rd_word[STATUS_VALID_BIT]   = valid;
        rd_word[STATUS_OVERRUN_BIT] = overrun;
      end
      IO_SEL_DATA:  rd_word = {{(32-SW_WIDTH){sign_ext & data_q[SW_WIDTH-1]}}, data_q};
      IO_SEL_COUNT: rd_word = {{(32-CNT_WIDTH){1'b0}}, press_cnt};
      IO_SEL_LIVE:  rd_word = {{(32-SW_WIDTH){1'b0}}, sw_s};
      default:      rd_word = '0;
    endcase
  end

  // The read mux samples pre-edge flags/data, so a read coinciding with a
  // capture returns the old value while the capture lands on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data   <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      data_q    <= '0;
      press_cnt <= '0;
    end else begin
      if (rd_en) rd_data <= rd_word;

      if (press) begin
        data_q    <= sw_s;
        press_cnt <= press_cnt + 1'b1;
      end

      if (press)        valid <= 1'b1;
      else if (data_rd) valid <= 1'b0;

      // A DATA read on the capture edge consumes the old value, so it is not
      // an overrun. Setting wins over a same-edge STATUS clear.
      if (press && valid && !data_rd) overrun <= 1'b1;
      else if (status_rd)             overrun <= 1'b0;
    end
  end

endmodule
